// File: rtl/timer_compare_datapath.sv
// Datapath slave for the timer-compare controller: digit counter, A/B operands,
// 4-bit ALU, result register, timer-set request and a stretched alarm output.
module timer_compare_datapath #(
  parameter int DIGITS    = 8,
  parameter int ALARM_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctl_kc,
  input  logic                  ctl_cc,
  input  logic                  ctl_la,
  input  logic                  ctl_lb,
  input  logic                  ctl_er,
  input  logic [1:0]            ctl_s,
  input  logic                  ctl_cin,
  input  logic                  ctl_m,
  input  logic [4*DIGITS-1:0]   time_bcd,
  input  logic [4*DIGITS-1:0]   alarm_bcd,
  input  logic                  ts_btn,
  input  logic                  alarm_stop,
  output logic                  ts,
  output logic                  c7,
  output logic                  az,
  output logic [2:0]            cnt,
  output logic [3:0]            r,
  output logic                  alarm
);

  localparam int TW = $clog2(ALARM_LEN + 1);

  logic [3:0]    a, b, alu;
  logic          ts_s1, ts_s2, ts_s3;
  logic          ts_edge;
  logic          m_prev;
  logic          m_edge;
  logic [TW-1:0] timer;

  assign c7      = (cnt == 3'(DIGITS - 1));
  assign az      = (r == '0);
  assign ts_edge = ts_s2 & ~ts_s3;
  assign m_edge  = ctl_m & ~m_prev;

  always_comb begin
    alu = '0;
    unique case (ctl_s)
      2'b00: alu = a + b + {3'b000, ctl_cin};
      2'b01: alu = a & b;
      2'b10: alu = a + ~b + {3'b000, ctl_cin};
      2'b11: alu = a ^ b;
    endcase
  end

  // Operand loads index with the pre-edge count, and R uses the pre-edge A/B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      a   <= '0;
      b   <= '0;
      r   <= '0;
    end else begin
      if (ctl_kc)
        cnt <= '0;
      else if (ctl_cc)
        cnt <= (cnt == 3'(DIGITS - 1)) ? '0 : cnt + 3'd1;
      if (ctl_la) a <= time_bcd[4*cnt +: 4];
      if (ctl_lb) b <= alarm_bcd[4*cnt +: 4];
      if (ctl_er) r <= alu;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_s1 <= 1'b0;
      ts_s2 <= 1'b0;
      ts_s3 <= 1'b0;
      ts    <= 1'b0;
    end else begin
      ts_s1 <= ts_btn;
      ts_s2 <= ts_s1;
      ts_s3 <= ts_s2;
      if (ts_edge)
        ts <= 1'b1;
      else if (ctl_kc)
        ts <= 1'b0;
    end
  end

  // Alarm clears on the edge the timer hits zero, so it stays high ALARM_LEN cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev <= 1'b0;
      alarm  <= 1'b0;
      timer  <= '0;
    end else begin
      m_prev <= ctl_m;
      if (alarm_stop) begin
        alarm <= 1'b0;
        timer <= '0;
      end else if (m_edge) begin
        alarm <= 1'b1;
        timer <= TW'(ALARM_LEN);
      end else if (alarm) begin
        timer <= timer - TW'(1);
        if (timer == TW'(1))
          alarm <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timer_compare_datapath.sv
// Directed self-checking bench for timer_compare_datapath (DIGITS=8, ALARM_LEN=16).
module tb_timer_compare_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctl_kc, ctl_cc, ctl_la, ctl_lb, ctl_er, ctl_cin, ctl_m;
  logic [1:0]  ctl_s;
  logic [31:0] time_bcd, alarm_bcd;
  logic        ts_btn, alarm_stop;
  logic        ts, c7, az, alarm;
  logic [2:0]  cnt;
  logic [3:0]  r;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  timer_compare_datapath #(.DIGITS(8), .ALARM_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .ctl_kc(ctl_kc), .ctl_cc(ctl_cc), .ctl_la(ctl_la), .ctl_lb(ctl_lb),
    .ctl_er(ctl_er), .ctl_s(ctl_s), .ctl_cin(ctl_cin), .ctl_m(ctl_m),
    .time_bcd(time_bcd), .alarm_bcd(alarm_bcd),
    .ts_btn(ts_btn), .alarm_stop(alarm_stop),
    .ts(ts), .c7(c7), .az(az), .cnt(cnt), .r(r), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {ctl_kc, ctl_cc, ctl_la, ctl_lb, ctl_er, ctl_cin, ctl_m} = '0;
    ctl_s = 2'b00;
    time_bcd  = 32'h12345678;
    alarm_bcd = 32'h12345679;
    ts_btn = 1'b0;
    alarm_stop = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_cnt",   32'(cnt),   32'd0);
    check("rst_r",     32'(r),     32'd0);
    check("rst_az",    32'(az),    32'd1);
    check("rst_c7",    32'(c7),    32'd0);
    check("rst_ts",    32'(ts),    32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_cnt", 32'(cnt), 32'd0);
    check("idle_az",  32'(az),  32'd1);

    // Counter sequence and wrap
    ctl_kc = 1'b1; tick(); ctl_kc = 1'b0;
    check("kc_cnt", 32'(cnt), 32'd0);
    ctl_cc = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("seq_cnt", 32'(cnt), 32'(i % 8));
      check("seq_c7",  32'(c7),  32'((i % 8) == 7));
    end
    ctl_kc = 1'b1; tick(); ctl_kc = 1'b0;
    check("kc_cc_cnt", 32'(cnt), 32'd0);

    // Asynchronous reset mid-pass
    for (int i = 0; i < 5; i++) tick();
    ctl_cc = 1'b0;
    check("pre_rst_cnt", 32'(cnt), 32'd5);
    rst = 1'b1;
    #2;
    check("async_rst_cnt", 32'(cnt), 32'd0);
    rst = 1'b0;
    tick();

    // ALU: digit 0 is A=8, B=9 -> 8-9 = F
    ctl_la = 1'b1; ctl_lb = 1'b1; tick(); ctl_la = 1'b0; ctl_lb = 1'b0;
    ctl_s = 2'b10; ctl_cin = 1'b1; ctl_er = 1'b1; tick(); ctl_er = 1'b0;
    check("sub0_r",  32'(r),  32'hF);
    check("sub0_az", 32'(az), 32'd0);
    ctl_s = 2'b00; ctl_cin = 1'b0; ctl_er = 1'b1; tick(); ctl_er = 1'b0;
    check("add0_r", 32'(r), 32'h1);
    // digit 1: A=7, B=7
    ctl_cc = 1'b1; tick(); ctl_cc = 1'b0;
    ctl_la = 1'b1; ctl_lb = 1'b1; tick(); ctl_la = 1'b0; ctl_lb = 1'b0;
    ctl_s = 2'b10; ctl_cin = 1'b1; ctl_er = 1'b1; tick(); ctl_er = 1'b0;
    check("sub1_r",  32'(r),  32'h0);
    check("sub1_az", 32'(az), 32'd1);
    ctl_s = 2'b01; ctl_cin = 1'b0; ctl_er = 1'b1; tick(); ctl_er = 1'b0;
    check("and1_r", 32'(r), 32'h7);
    ctl_s = 2'b11; ctl_er = 1'b1; tick(); ctl_er = 1'b0;
    check("xor1_r", 32'(r), 32'h0);
    // Same-cycle load/increment/result: R from old A/B (7+7+1), loads from old cnt (digit 1)
    ctl_s = 2'b00; ctl_cin = 1'b1;
    ctl_cc = 1'b1; ctl_la = 1'b1; ctl_lb = 1'b1; ctl_er = 1'b1; tick();
    ctl_cc = 1'b0; ctl_la = 1'b0; ctl_lb = 1'b0;
    check("same_r",   32'(r),   32'hF);
    check("same_cnt", 32'(cnt), 32'd2);
    ctl_cin = 1'b0; tick(); ctl_er = 1'b0;
    check("preedge_ld_r", 32'(r), 32'hE);

    // Timer-set request
    ts_btn = 1'b1;
    tick(); check("ts_e1", 32'(ts), 32'd0);
    tick(); check("ts_e2", 32'(ts), 32'd0);
    tick(); check("ts_e3", 32'(ts), 32'd1);
    tick(); tick(); ts_btn = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ctl_kc = 1'b1; tick(); ctl_kc = 1'b0;
    check("ts_clr", 32'(ts), 32'd0);
    ts_btn = 1'b1;
    tick(); tick();
    check("ts2_e2", 32'(ts), 32'd0);
    ctl_kc = 1'b1; tick(); ctl_kc = 1'b0;
    check("ts_set_wins", 32'(ts), 32'd1);
    ts_btn = 1'b0;
    ctl_kc = 1'b1; tick(); ctl_kc = 1'b0;
    check("ts_clr2", 32'(ts), 32'd0);
    for (int i = 0; i < 4; i++) tick();

    // Alarm: single pulse, 16 cycles
    ctl_m = 1'b1; tick(); ctl_m = 1'b0;
    check("al_k0", 32'(alarm), 32'd1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("al_single", 32'(alarm), 32'(k < 16));
    end

    // Retrigger 10 cycles after first pulse
    ctl_m = 1'b1; tick(); ctl_m = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    check("al_pre_retrig", 32'(alarm), 32'd1);
    ctl_m = 1'b1; tick(); ctl_m = 1'b0;
    check("al_retrig", 32'(alarm), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("al_retrig_len", 32'(alarm), 32'(k < 16));
    end

    // Stop coincident with edge, then stop mid-alarm
    ctl_m = 1'b1; alarm_stop = 1'b1; tick(); alarm_stop = 1'b0;
    check("al_stop_edge", 32'(alarm), 32'd0);
    ctl_m = 1'b0; tick();
    check("al_stop_after", 32'(alarm), 32'd0);
    ctl_m = 1'b1; tick(); ctl_m = 1'b0;
    tick(); tick();
    alarm_stop = 1'b1; tick(); alarm_stop = 1'b0;
    check("al_stop_mid", 32'(alarm), 32'd0);
    tick();
    check("al_stop_stays", 32'(alarm), 32'd0);

    // Held level: one 16-cycle alarm
    ctl_m = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      check("al_held", 32'(alarm), 32'(k < 16));
    end
    ctl_m = 1'b0;
    tick();
    check("al_held_end", 32'(alarm), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/timer_compare_datapath.md
# timer_compare_datapath

Datapath slave for the timer-compare controller in the digital clock. It executes the controller's registered control word each clock: digit counter, A/B operand registers, 4-bit ALU and result register. It returns the status flags `ts`, `c7` and `az` that the controller branches on. It also stretches the controller's match strobe into a bounded alarm output that drives the buzzer/LED.

## Interface
Parameters:
- `DIGITS`, 8 — BCD digits compared per pass; counter width is 3 bits, so `DIGITS` ≤ 8.
- `ALARM_LEN`, 16 — alarm duration in clock cycles, ≥ 1.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `ctl_kc`  in  1  clear digit counter.
- `ctl_cc`  in  1  increment digit counter.
- `ctl_la`  in  1  load A from selected time digit.
- `ctl_lb`  in  1  load B from selected alarm digit.
- `ctl_er`  in  1  load R from ALU output.
- `ctl_s`  in  2  ALU operation select.
- `ctl_cin`  in  1  ALU carry-in.
- `ctl_m`  in  1  match strobe from controller.
- `time_bcd`  in  4*DIGITS  current time digits; digit i at bits [4i+3:4i].
- `alarm_bcd`  in  4*DIGITS  alarm setpoint digits, same packing.
- `ts_btn`  in  1  raw timer-set button, asynchronous to `clk`.
- `alarm_stop`  in  1  user silence request, synchronous.
- `ts`  out  1  timer-set request pending.
- `c7`  out  1  counter is at the last digit.
- `az`  out  1  R equals zero.
- `cnt`  out  3  digit counter.
- `r`  out  4  result register.
- `alarm`  out  1  alarm active.

## Operation
- Digit counter `cnt`:
  - `ctl_kc` → 0. This has priority over `ctl_cc`.
  - Otherwise `ctl_cc` → `cnt`+1, wrapping from `DIGITS`-1 to 0.
  - `c7` = (`cnt` == `DIGITS`-1), decoded from the registered count.
- Operands:
  - `ctl_la` loads A ← `time_bcd[4*cnt+:4]`.
  - `ctl_lb` loads B ← `alarm_bcd[4*cnt+:4]`.
  - Both loads use the pre-edge `cnt`, even when `ctl_cc` or `ctl_kc` is asserted in the same cycle.
- ALU, combinational on registered A and B, 4-bit result, carry-out discarded:
  - `ctl_s`=00: A+B+cin.
  - 01: A AND B.
  - 10: A+~B+cin, which is subtraction when cin=1.
  - 11: A XOR B.
- Result register: `ctl_er` loads R ← ALU result, computed from the pre-edge A and B. A same-cycle `ctl_la`/`ctl_lb` does not affect that R value.
- Zero flag: `az` = (R == 0).
- Timer-set request:
  - `ts_btn` passes through a two-flop synchronizer, then a rising-edge detector.
  - A detected edge sets `ts`.
  - `ctl_kc` clears `ts`.
  - If an edge and `ctl_kc` occur in the same cycle, set wins, so no press is lost.
- Alarm:
  - A rising edge of `ctl_m` (registered previous value) sets `alarm` and loads the down-timer with `ALARM_LEN`.
  - While `alarm`=1 the timer decrements each cycle. `alarm` clears in the cycle the timer reaches 0, giving exactly `ALARM_LEN` cycles high.
  - A new `ctl_m` edge while `alarm` is active reloads the timer (retrigger).
  - `alarm_stop` clears `alarm` and the timer. It has priority over a simultaneous `ctl_m` edge.
  - A `ctl_m` level held high never retriggers.
- Asserting `rst` clears all state asynchronously, including mid-pass. Operation resumes on the first edge after deassertion.

## Timing
- Reset values:
  - `cnt`=0, A=B=0, `r`=0.
  - `az`=1, `c7`=0 (for `DIGITS`>1), `ts`=0, `alarm`=0.
  - Synchronizer flops, edge registers and alarm timer are all 0.
- Control inputs are sampled at edge N. `cnt`, `r`, `az`, `c7`, `ts` and `alarm` are valid after edge N, with no further latency.
- The controller's registered outputs arrive one cycle after its state. The status flags are registered here, so the controller sees them one state after issuing the control. This is consistent with the controller's Ts/c7/Az branch points.
- `ts` latency: a `ts_btn` rise is visible on `ts` 3 edges later (2 synchronizer stages + edge register).
- Alarm latency: `alarm` rises on the edge that samples the `ctl_m` rising edge.
- All control inputs are independent; any combination is legal. Priorities are as listed above.

## Test plan
- Reset release, all controls 0 → `cnt`=0, `r`=0, `az`=1, `ts`=0, `alarm`=0. Assert `rst` mid-pass at `cnt`=5 → `cnt` returns to 0 immediately, without waiting for a clock edge.
- `ctl_kc` then 9× `ctl_cc` → `cnt` sequence 0,1,…,7,0,1. `c7`=1 only while `cnt`=7. `ctl_kc` with `ctl_cc` in the same cycle → `cnt`=0.
- `time_bcd`=0x12345678, `alarm_bcd`=0x12345679, `cnt`=0: `ctl_la`+`ctl_lb`, then `ctl_s`=10, `ctl_cin`=1, `ctl_er` → `r`=0xF, `az`=0. Repeat at `cnt`=1 → `r`=0, `az`=1.
- Pulse `ts_btn` high 5 cycles → `ts`=1 three edges after the rise. `ctl_kc` coincident with a second edge → `ts` stays 1. `ctl_kc` alone → `ts`=0.
- `ctl_m` 1-cycle pulse, `ALARM_LEN`=16 → `alarm` high exactly 16 cycles.
  - Second pulse at cycle 10 → 16 more cycles from the retrigger.
  - `alarm_stop` coincident with a `ctl_m` edge → `alarm`=0.
  - `ctl_m` held high 40 cycles → a single 16-cycle alarm.
